brent_kung_pipe_adder: RTL and testbench

//   Parametrised, pipelined Brent-Kung prefix adder/subtractor with a valid/ready stream interface.

---
 rtl/brent_kung_pipe_adder.sv | 155 +++++++++++++++
 tb/tb_brent_kung_pipe_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/brent_kung_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with a valid/ready stream and a global stall.
// Optional signed-overflow output is enabled by defining BK_OVF_FLAG_EN.
module brent_kung_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int SUB_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BK_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int LVLS = $clog2(WIDTH);

  logic             w_en;
  logic             w_sub;
  logic             w_c0;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_gbit0;

  logic             r_vld_p0, r_vld_p1, r_vld_p2;
  logic [WIDTH-1:0] r_p_p0, r_g_p0;
  logic             r_c0_p0;

  logic [WIDTH-1:0] w_gu, w_pu;
  logic [WIDTH-1:0] r_gu_p1, r_pu_p1, r_p_p1;
  logic             r_c0_p1;

  logic [WIDTH-1:0] w_gd;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum_p2;
  logic             r_cout_p2;

  assign w_en     = !r_vld_p2 || out_ready;
  assign in_ready = w_en;

  assign w_sub   = (SUB_EN != 0) && op_sub;
  assign w_b     = in2 ^ {WIDTH{w_sub}};
  assign w_c0    = w_sub || cin;
  assign w_p     = in1 ^ w_b;
  assign w_g     = in1 & w_b;
  assign w_gbit0 = w_g[0] | (w_p[0] & w_c0);

  // S0: operand capture; bit 0 generate already folds in the carry-in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_p_p0   <= '0;
      r_g_p0   <= '0;
      r_c0_p0  <= 1'b0;
    end else if (w_en) begin
      r_vld_p0 <= in_valid;
      r_p_p0   <= w_p;
      r_g_p0   <= {w_g[WIDTH-1:1], w_gbit0};
      r_c0_p0  <= w_c0;
    end
  end

  always_comb begin
    w_gu = r_g_p0;
    w_pu = r_p_p0;
    for (int l = 0; l < LVLS; l++) begin
      for (int i = (1 << (l + 1)) - 1; i < WIDTH; i += (1 << (l + 1))) begin
        w_gu[i] = w_gu[i] | (w_pu[i] & w_gu[i - (1 << l)]);
        w_pu[i] = w_pu[i] & w_pu[i - (1 << l)];
      end
    end
  end

  // S1: up-sweep tree nodes registered alongside bitwise propagate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_gu_p1  <= '0;
      r_pu_p1  <= '0;
      r_p_p1   <= '0;
      r_c0_p1  <= 1'b0;
    end else if (w_en) begin
      r_vld_p1 <= r_vld_p0;
      r_gu_p1  <= w_gu;
      r_pu_p1  <= w_pu;
      r_p_p1   <= r_p_p0;
      r_c0_p1  <= r_c0_p0;
    end
  end

  // Down-sweep only needs group generate; each node is finished exactly once.
  always_comb begin
    w_gd = r_gu_p1;
    for (int l = LVLS - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (1 << (l + 1))) begin
        w_gd[i] = w_gd[i] | (r_pu_p1[i] & w_gd[i - (1 << l)]);
      end
    end
  end

  assign w_sum = r_p_p1 ^ {w_gd[WIDTH-2:0], r_c0_p1};

  // S2: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_sum_p2  <= '0;
      r_cout_p2 <= 1'b0;
    end else if (w_en) begin
      r_vld_p2  <= r_vld_p1;
      r_sum_p2  <= w_sum;
      r_cout_p2 <= w_gd[WIDTH-1];
    end
  end

  assign out_valid = r_vld_p2;
  assign sum       = r_sum_p2;
  assign cout      = r_cout_p2;

`ifdef BK_OVF_FLAG_EN
  logic r_amsb_p0, r_bmsb_p0, r_amsb_p1, r_bmsb_p1, r_ovf_p2;
  logic w_ovf;

  assign w_ovf = (r_amsb_p1 == r_bmsb_p1) && (w_sum[WIDTH-1] != r_amsb_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_amsb_p0 <= 1'b0;
      r_bmsb_p0 <= 1'b0;
      r_amsb_p1 <= 1'b0;
      r_bmsb_p1 <= 1'b0;
      r_ovf_p2  <= 1'b0;
    end else if (w_en) begin
      r_amsb_p0 <= in1[WIDTH-1];
      r_bmsb_p0 <= w_b[WIDTH-1];
      r_amsb_p1 <= r_amsb_p0;
      r_bmsb_p1 <= r_bmsb_p0;
      r_ovf_p2  <= w_ovf;
    end
  end

  assign ovf = r_ovf_p2;
`endif

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// Scoreboard bench for brent_kung_pipe_adder (WIDTH=16); checks ovf when BK_OVF_FLAG_EN is defined.
module tb_brent_kung_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BK_OVF_FLAG_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  logic took = 1'b0;

  always #5 clk = ~clk;

  brent_kung_pipe_adder #(.WIDTH(W), .SUB_EN(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef BK_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   r;
    exp_t         e;
    bb  = sb ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.s = r[W-1:0];
    e.c = r[W];
    e.v = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb, input logic ordy, input exp_t e);
    exp_t x;
    @(negedge clk);
    in_valid  = iv;
    in1       = a;
    in2       = b;
    cin       = ci;
    op_sub    = sb;
    out_ready = ordy;
    #1;
    took = iv && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        x = sbq.pop_front();
        n_pop++;
        check("sum", {16'h0, sum}, {16'h0, x.s});
        check("cout", {31'h0, cout}, {31'h0, x.c});
`ifdef BK_OVF_FLAG_EN
        check("ovf", {31'h0, ovf}, {31'h0, x.v});
`endif
      end
    end
    if (took) sbq.push_back(e);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, '0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sb, input exp_t e);
    took = 1'b0;
    for (int t = 0; t < 50 && !took; t++) cycle(1'b1, a, b, ci, sb, 1'b1, e);
    if (!took) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           lat;
    int           pop0;
    int           k;
    logic         ordy;
    logic [W-1:0] a, b;
    logic         ci, sb;

    // Reset state
    #12;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_sum", {16'h0, sum}, 32'd0);
    check("rst_cout", {31'h0, cout}, 32'd0);
`ifdef BK_OVF_FLAG_EN
    check("rst_ovf", {31'h0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("in_ready_after_rst", {31'h0, in_ready}, 32'd1);

    // Latency and directed arithmetic
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0});
    lat  = 0;
    pop0 = n_pop;
    while (n_pop == pop0 && lat < 10) begin
      idle(1'b1);
      lat++;
    end
    check("latency", lat, 32'd3);

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, c: 1'b0, v: 1'b1});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, '{s: 16'hFFFE, c: 1'b0, v: 1'b0});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, '{s: 16'hFFFE, c: 1'b0, v: 1'b0});
    send(16'h1234, 16'h4321, 1'b1, 1'b0, '{s: 16'h5556, c: 1'b0, v: 1'b0});
    send(16'h0009, 16'h0003, 1'b0, 1'b1, '{s: 16'h0006, c: 1'b1, v: 1'b0});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, c: 1'b1, v: 1'b1});
    repeat (6) idle(1'b1);
    check("directed_drained", sbq.size(), 32'd0);

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 4-6
    pop0 = n_pop;
    k    = 0;
    for (int c = 0; c < 30; c++) begin
      ordy = !(c >= 4 && c <= 6);
      if (k < 8) begin
        a = 16'h1000 + W'(k * 16'h0111);
        b = W'(k);
        cycle(1'b1, a, b, 1'b0, 1'b0, ordy, model(a, b, 1'b0, 1'b0));
        if (took) k++;
      end else begin
        idle(ordy);
      end
      if (!ordy && out_valid) check("in_ready_stall", {31'h0, in_ready}, 32'd0);
    end
    check("bp_sent", k, 32'd8);
    check("bp_count", n_pop - pop0, 32'd8);

    // Reset with three beats in flight
    for (int j = 0; j < 3; j++) begin
      a = 16'h2000 + W'(j);
      cycle(1'b1, a, 16'h0100, 1'b0, 1'b0, 1'b1, model(a, 16'h0100, 1'b0, 1'b0));
    end
    @(negedge clk);
    check("pre_rst_valid", {31'h0, out_valid}, 32'd1);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_sum", {16'h0, sum}, 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) idle(1'b1);

    // Random stream with random backpressure and bubbles
    for (int n = 0; n < 3000; n++) begin
      a  = W'($urandom());
      b  = W'($urandom());
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 1)) idle($urandom_range(0, 3) != 0);
      took = 1'b0;
      for (int t = 0; t < 100 && !took; t++)
        cycle(1'b1, a, b, ci, sb, $urandom_range(0, 3) != 0, model(a, b, ci, sb));
      if (!took) check("accept_timeout", 32'd0, 32'd1);
    end
    for (int t = 0; t < 50 && sbq.size() != 0; t++) idle(1'b1);
    check("sb_empty", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
